// File: rtl/pipe_pkg.sv
// Shared types and default widths for the in-order pipeline tracking chain.
package pipe_pkg;
    localparam int DEF_NSTAGE = 4;
    localparam int DEF_WIDTH  = 32;
    localparam int DEF_TAG_W  = 3;

    // Index width that stays at least one bit for the smallest legal chain.
    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_FIDX_W = idx_w(DEF_NSTAGE);

    typedef struct packed {
        logic                  v;
        logic                  we;
        logic [DEF_TAG_W-1:0]  dst;
        logic [DEF_WIDTH-1:0]  data;
    } slot_t;
endpackage

// File: rtl/pipe_if.sv
// Producer/consumer handshake of the tracking chain: input offer and output slot view.
interface pipe_if #(
    parameter int WIDTH = pipe_pkg::DEF_WIDTH,
    parameter int TAG_W = pipe_pkg::DEF_TAG_W
);
    logic             in_v;
    logic [WIDTH-1:0] in_data;
    logic             in_we;
    logic [TAG_W-1:0] in_dst;
    logic             in_rdy;
    logic             out_v;
    logic [WIDTH-1:0] out_data;
    logic             out_we;
    logic [TAG_W-1:0] out_dst;
    logic             out_fire;

    modport master (
        output in_v, in_data, in_we, in_dst,
        input  in_rdy, out_v, out_data, out_we, out_dst, out_fire
    );

    modport slave (
        input  in_v, in_data, in_we, in_dst,
        output in_rdy, out_v, out_data, out_we, out_dst, out_fire
    );
endinterface

// File: rtl/pipe_slot.sv
// One tracked slot: holds, loads from upstream, or is killed; reports a tag match.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             kill,
    input  logic             ld_v,
    input  logic             ld_we,
    input  logic [TAG_W-1:0] ld_dst,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [TAG_W-1:0] q_tag,
    output logic             v,
    output logic             we,
    output logic [TAG_W-1:0] dst,
    output logic [WIDTH-1:0] data,
    output logic             hit
);
    logic             v_reg;
    logic             we_reg;
    logic [TAG_W-1:0] dst_reg;
    logic [WIDTH-1:0] data_reg;

    // Kill only clears valid; the payload of a dead slot is never observed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_reg    <= 1'b0;
            we_reg   <= 1'b0;
            dst_reg  <= '0;
            data_reg <= '0;
        end else begin
            if (kill)
                v_reg <= 1'b0;
            else if (!hold)
                v_reg <= ld_v;
            if (!hold) begin
                we_reg   <= ld_we;
                dst_reg  <= ld_dst;
                data_reg <= ld_data;
            end
        end
    end

    assign v    = v_reg;
    assign we   = we_reg;
    assign dst  = dst_reg;
    assign data = data_reg;
    assign hit  = v_reg & we_reg & (dst_reg == q_tag);
endmodule

// File: rtl/pipe_track.sv
// In-order tracking chain between decode and writeback: stall-driven hold chain,
// bubble collapse, partial flush of younger slots, occupancy and dependency lookup.
module pipe_track
    import pipe_pkg::*;
#(
    parameter  int NSTAGE = DEF_NSTAGE,
    parameter  int WIDTH  = DEF_WIDTH,
    parameter  int TAG_W  = DEF_TAG_W,
    parameter  int CNT_W  = $clog2(NSTAGE + 1),
    localparam int FIDX_W = idx_w(NSTAGE)
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_if.slave             io,
    input  logic [NSTAGE-1:0] stage_stall,
    input  logic              flush,
    input  logic [FIDX_W-1:0] flush_idx,
    input  logic [TAG_W-1:0]  q_tag,
    output logic              dep_hit,
    output logic [NSTAGE-1:0] slot_v,
    output logic [CNT_W-1:0]  occ
);
    logic [NSTAGE-1:0] v;
    logic [NSTAGE-1:0] we;
    logic [NSTAGE-1:0] hit;
    logic [NSTAGE-1:0] kill;
    logic [NSTAGE:0]   hold;
    logic [NSTAGE-1:0] ld_v;
    logic [NSTAGE-1:0] ld_we;
    logic [TAG_W-1:0]  ld_dst  [NSTAGE];
    logic [WIDTH-1:0]  ld_data [NSTAGE];
    logic [TAG_W-1:0]  dst     [NSTAGE];
    logic [WIDTH-1:0]  data    [NSTAGE];
    logic [CNT_W-1:0]  kill_cnt;
    logic [CNT_W-1:0]  occ_reg;
    logic [CNT_W-1:0]  occ_next;
    logic              in_accept;
    logic              out_fire;

    // Only a valid slot can hold, so empty slots keep absorbing from upstream.
    always_comb begin
        hold = '0;
        for (int k = NSTAGE - 1; k >= 0; k--)
            hold[k] = v[k] & (stage_stall[k] | hold[k+1]);
    end

    always_comb begin
        kill     = '0;
        kill_cnt = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            kill[k]  = flush & (k < int'(flush_idx));
            kill_cnt = kill_cnt + CNT_W'(v[k] & kill[k]);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NSTAGE; gi++) begin : g_slot
            if (gi == 0) begin : g_head
                assign ld_v[gi]    = io.in_v & ~flush;
                assign ld_we[gi]   = io.in_we;
                assign ld_dst[gi]  = io.in_dst;
                assign ld_data[gi] = io.in_data;
            end else begin : g_body
                // A held or killed upstream slot hands down a bubble.
                assign ld_v[gi]    = v[gi-1] & ~hold[gi-1] & ~kill[gi-1];
                assign ld_we[gi]   = we[gi-1];
                assign ld_dst[gi]  = dst[gi-1];
                assign ld_data[gi] = data[gi-1];
            end

            pipe_slot #(
                .WIDTH (WIDTH),
                .TAG_W (TAG_W)
            ) u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .hold    (hold[gi]),
                .kill    (kill[gi]),
                .ld_v    (ld_v[gi]),
                .ld_we   (ld_we[gi]),
                .ld_dst  (ld_dst[gi]),
                .ld_data (ld_data[gi]),
                .q_tag   (q_tag),
                .v       (v[gi]),
                .we      (we[gi]),
                .dst     (dst[gi]),
                .data    (data[gi]),
                .hit     (hit[gi])
            );
        end
    endgenerate

    assign in_accept = io.in_v & ~hold[0] & ~flush;
    assign out_fire  = v[NSTAGE-1] & ~stage_stall[NSTAGE-1];
    assign occ_next  = occ_reg + CNT_W'(in_accept) - CNT_W'(out_fire) - kill_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            occ_reg <= '0;
        else
            occ_reg <= occ_next;
    end

    // A flushed input is still consumed so the producer does not replay it.
    assign io.in_rdy   = ~hold[0] | flush;
    assign io.out_v    = v[NSTAGE-1];
    assign io.out_we   = we[NSTAGE-1];
    assign io.out_dst  = dst[NSTAGE-1];
    assign io.out_data = data[NSTAGE-1];
    assign io.out_fire = out_fire;

    assign dep_hit = |hit;
    assign slot_v  = v;
    assign occ     = occ_reg;
endmodule
